dice_roll_ctrl: RTL and testbench
=================================

# dice_roll_ctrl

Dice-roll sequencer that sits directly downstream of the double-synchroniser button debouncer. It turns the debounced button level into a throw:
- While the button is held, the die face spins at a fixed rate.
- On release, the face decelerates over a fixed number of steps and settles.
- When it settles, the block flags the result and counts the throw.

The face output feeds the seven-segment/LED display stage. `stop` gives the rest of the design a global freeze.

## Interface
Parameters:
- `ROLL_DIV`, 4: clock cycles per face step while rolling; legal range 1..255.
- `SLOW_STEPS`, 6: number of decelerating steps after release; legal range 1..15. `ROLL_DIV*SLOW_STEPS` must be < 65536.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stop`  in  1  synchronous freeze/abort, active high.
- `btn_in`  in  1  debounced button level from the debouncer's `btn_out`; already synchronous to `clk`.
- `face`  out  3  current die face, always in 1..6.
- `rolling`  out  1  high in the ROLL and SLOW states.
- `done`  out  1  one-cycle pulse when a throw settles.
- `throws`  out  8  count of completed throws.

## Operation
- `btn_in` is registered into `btn_prev` (reset value 0).
  - rise = `btn_in & ~btn_prev`.
  - fall = `~btn_in & btn_prev`.
- Face stepping:
  - A step advances `face` by +1, with 6 wrapping to 1.
  - `face` never takes the value 0 or 7.
- State machine has four states: IDLE, ROLL, SLOW, DONE. All outputs are registered or Moore-decoded.
- IDLE:
  - `face` holds its value.
  - A rise moves the FSM to ROLL and clears the 16-bit divider `cnt`.
  - A fall is ignored.
- ROLL:
  - `cnt` counts 0..`ROLL_DIV`-1.
  - In each cycle where `cnt==ROLL_DIV-1`, `face` steps and `cnt` returns to 0.
  - A fall moves the FSM to SLOW, clears `cnt` and clears step index `k` (4-bit). `face` does not step in that cycle, even if `cnt==ROLL_DIV-1`.
- SLOW:
  - Step k lasts `ROLL_DIV*(k+1)` cycles.
  - In each cycle where `cnt==ROLL_DIV*(k+1)-1`, `face` steps, `cnt` clears and `k` increments.
  - If the step just taken was step `SLOW_STEPS-1`, the FSM moves to DONE.
  - Rise and fall are both ignored in this state; the throw always completes.
- DONE:
  - Lasts exactly one cycle, with `done=1`.
  - `throws` increments on entry, wrapping 255 to 0.
  - The next state is always IDLE.
  - A rise seen in the DONE cycle is ignored. If the button is still or again held, a new throw needs a new release and press.
- `stop`:
  - Has priority over every transition, including a rise or a settle step in the same cycle.
  - While `stop=1`, the next state is IDLE and `cnt` and `k` clear.
  - `face` and `throws` hold, and `done` is never asserted.
  - `btn_prev` keeps tracking `btn_in`. If the button is held when `stop` is released, no throw starts until a fresh rise.
- Reset (`rst_n` low, at any time, including mid-roll):
  - Outputs are immediately `face=1`, `rolling=0`, `done=0`, `throws=0`.
  - Internally, state=IDLE and `cnt`, `k` and `btn_prev` are 0.

## Timing
- Latency from a rise to the start of rolling:
  - A rise is sampled at edge N.
  - `rolling=1` from edge N+1.
  - The first face step is at edge N+`ROLL_DIV`.
- Latency from release to done:
  - A fall is sampled at edge M, entering SLOW.
  - Settling takes `ROLL_DIV*SLOW_STEPS*(SLOW_STEPS+1)/2` further cycles.
  - The next edge enters DONE, so `done` is high for the following cycle.
  - `rolling` drops to 0 in the same cycle that `done` rises.
- Total face steps in one throw = floor(ROLL cycles / `ROLL_DIV`) + `SLOW_STEPS`, taken mod 6.
- `ROLL_DIV=1`: `face` steps every cycle in ROLL, and step k in SLOW lasts k+1 cycles.
- A press shorter than `ROLL_DIV` cycles still completes a full SLOW phase and asserts `done` once.

## Test plan
- Reset: hold `rst_n` low for 3 cycles with `btn_in` toggling -> `face=1`, `rolling=0`, `done=0`, `throws=0` throughout, with no FSM activity.
- Basic throw, `ROLL_DIV=4`, `SLOW_STEPS=3`, starting from `face=1`:
  - Stimulus: rise, then exactly 28 cycles in ROLL, then release.
  - `face` reads 2 at release (7 steps).
  - SLOW steps land on 3, 4 and 5 after 4, 8 and 12 cycles.
  - `done` pulses once and `face=5`, `throws=1`.
- Short press, `ROLL_DIV=4`, `SLOW_STEPS=3`:
  - Stimulus: `btn_in` high for 2 cycles.
  - `face` goes 1 -> 4 and `done` asserts 24 cycles after the fall.
  - `rolling` is high from the cycle after the rise until `done`.
- Ignore during SLOW and DONE: re-press the button mid-SLOW and hold it through DONE -> no extra throw and a single `done` pulse. A new throw starts only after a release and a fresh press.
- `stop` abort:
  - Assert `stop` for 1 cycle mid-ROLL at `face=4` while the button is held -> next state IDLE, `face` stays 4, no `done`, `throws` unchanged.
  - Releasing and re-pressing the button afterwards starts a normal throw.
- Counter wrap: perform 256 throws with `ROLL_DIV=1`, `SLOW_STEPS=1` -> `throws` reads 255 and then 0.
  - Check `face` stays in 1..6 every cycle across all throws.
  - Each throw yields exactly one `done`.

Source files
------------

// File: rtl/dice_roll_ctrl.sv
// Dice-roll sequencer: spins the face while the button is held,
// decelerates over SLOW_STEPS steps after release, then flags the throw.
module dice_roll_ctrl #(
  parameter int ROLL_DIV   = 4,
  parameter int SLOW_STEPS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stop,
  input  logic       btn_in,
  output logic [2:0] face,
  output logic       rolling,
  output logic       done,
  output logic [7:0] throws
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_SLOW,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_DIV_M1 = 16'(ROLL_DIV - 1);
  localparam logic [3:0]  LP_LAST   = 4'(SLOW_STEPS - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [3:0]  r_k;
  logic [3:0]  w_k_nxt;
  logic        r_btn_prev;
  logic [2:0]  r_face;
  logic [2:0]  w_face_nxt;
  logic [7:0]  r_throws;
  logic [7:0]  w_throws_nxt;

  logic        w_rise;
  logic        w_fall;
  logic [2:0]  w_face_step;
  logic [15:0] w_slow_end;

  assign w_rise = btn_in & ~r_btn_prev;
  assign w_fall = ~btn_in & r_btn_prev;

  assign w_face_step = (r_face == 3'd6) ? 3'd1 : r_face + 3'd1;

  // Step k of the slow-down lasts ROLL_DIV*(k+1) cycles.
  assign w_slow_end =
    16'(ROLL_DIV * (int'({28'd0, r_k}) + 1) - 1);

  always_comb begin
    w_next       = r_state;
    w_cnt_nxt    = r_cnt;
    w_k_nxt      = r_k;
    w_face_nxt   = r_face;
    w_throws_nxt = r_throws;
    if (stop) begin
      w_next    = S_IDLE;
      w_cnt_nxt = '0;
      w_k_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            w_next    = S_ROLL;
            w_cnt_nxt = '0;
          end
        end
        S_ROLL: begin
          if (w_fall) begin
            w_next    = S_SLOW;
            w_cnt_nxt = '0;
            w_k_nxt   = '0;
          end else if (r_cnt == LP_DIV_M1) begin
            w_face_nxt = w_face_step;
            w_cnt_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_SLOW: begin
          if (r_cnt == w_slow_end) begin
            w_face_nxt = w_face_step;
            w_cnt_nxt  = '0;
            w_k_nxt    = r_k + 4'd1;
            if (r_k == LP_LAST) begin
              w_next       = S_DONE;
              w_throws_nxt = r_throws + 8'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_k        <= '0;
      r_btn_prev <= 1'b0;
      r_face     <= 3'd1;
      r_throws   <= '0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_nxt;
      r_k        <= w_k_nxt;
      r_btn_prev <= btn_in;
      r_face     <= w_face_nxt;
      r_throws   <= w_throws_nxt;
    end
  end

  assign face    = r_face;
  assign rolling = (r_state == S_ROLL) || (r_state == S_SLOW);
  assign done    = (r_state == S_DONE);
  assign throws  = r_throws;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Bench for dice_roll_ctrl: directed table, hand sequences and
// random stimulus against a cycle-level behavioural model.
module tb_dice_roll_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic       btn_in;
  logic [2:0] face_a, face_b;
  logic       rolling_a, rolling_b;
  logic       done_a, done_b;
  logic [7:0] throws_a, throws_b;

  always #5 clk = ~clk;

  dice_roll_ctrl #(.ROLL_DIV(4), .SLOW_STEPS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .stop(stop), .btn_in(btn_in),
    .face(face_a), .rolling(rolling_a), .done(done_a),
    .throws(throws_a)
  );

  dice_roll_ctrl #(.ROLL_DIV(1), .SLOW_STEPS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .stop(stop), .btn_in(btn_in),
    .face(face_b), .rolling(rolling_b), .done(done_b),
    .throws(throws_b)
  );

  localparam int M_IDLE = 0;
  localparam int M_ROLL = 1;
  localparam int M_SLOW = 2;
  localparam int M_DONE = 3;

  int n_vec = 0;
  int n_bad = 0;

  int m_div[2]   = '{4, 1};
  int m_steps[2] = '{3, 1};
  int m_mode[2];
  int m_t[2];
  int m_face[2];
  int m_thr[2];
  bit m_prev[2];

  typedef struct {
    bit stp;
    bit btn;
    int n;
    int face;
    int roll;
    int dn;
    int thr;
  } vec_t;

  vec_t tbl[$];

  function automatic int pk(int f, int r, int d, int t);
    return (f << 10) | (r << 9) | (d << 8) | (t & 255);
  endfunction

  function automatic int nxt(int f);
    return (f == 6) ? 1 : f + 1;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE;
      m_t[i]    = 0;
      m_face[i] = 1;
      m_thr[i]  = 0;
      m_prev[i] = 1'b0;
    end
  endtask

  task automatic m_step(input bit s, input bit b);
    for (int i = 0; i < 2; i++) begin
      bit rise;
      bit fall;
      int tot;
      rise = b & ~m_prev[i];
      fall = ~b & m_prev[i];
      tot  = m_div[i] * m_steps[i] * (m_steps[i] + 1) / 2;
      if (s) begin
        m_mode[i] = M_IDLE;
      end else begin
        case (m_mode[i])
          M_IDLE: if (rise) begin
            m_mode[i] = M_ROLL;
            m_t[i]    = 0;
          end
          M_ROLL: if (fall) begin
            m_mode[i] = M_SLOW;
            m_t[i]    = 0;
          end else begin
            if ((m_t[i] + 1) % m_div[i] == 0)
              m_face[i] = nxt(m_face[i]);
            m_t[i]++;
          end
          M_SLOW: begin
            m_t[i]++;
            for (int j = 1; j <= m_steps[i]; j++)
              if (m_t[i] == m_div[i] * j * (j + 1) / 2)
                m_face[i] = nxt(m_face[i]);
            if (m_t[i] == tot) begin
              m_mode[i] = M_DONE;
              m_thr[i]  = (m_thr[i] + 1) % 256;
            end
          end
          default: m_mode[i] = M_IDLE;
        endcase
      end
      m_prev[i] = b;
    end
  endtask

  function automatic int m_pk(int i);
    int r;
    r = (m_mode[i] == M_ROLL || m_mode[i] == M_SLOW) ? 1 : 0;
    return pk(m_face[i], r, (m_mode[i] == M_DONE) ? 1 : 0, m_thr[i]);
  endfunction

  function automatic int pk_a();
    return pk(int'(face_a), int'(rolling_a), int'(done_a),
              int'(throws_a));
  endfunction

  function automatic int pk_b();
    return pk(int'(face_b), int'(rolling_b), int'(done_b),
              int'(throws_b));
  endfunction

  task automatic cmp_model();
    chk("model_a", pk_a(), m_pk(0));
    chk("model_b", pk_b(), m_pk(1));
    chk("face_range_a", int'(face_a >= 3'd1 && face_a <= 3'd6), 1);
    chk("face_range_b", int'(face_b >= 3'd1 && face_b <= 3'd6), 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step(stop, btn_in);
    #1;
    cmp_model();
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_a"}, pk_a(), pk(1, 0, 0, 0));
    chk({nm, "_b"}, pk_b(), pk(1, 0, 0, 0));
  endtask

  task automatic add(input bit s, input bit b, input int n,
                     input int f, input int r, input int d,
                     input int t);
    vec_t v;
    v.stp = s; v.btn = b; v.n = n;
    v.face = f; v.roll = r; v.dn = d; v.thr = t;
    tbl.push_back(v);
  endtask

  initial begin
    int ndone;
    int hold;

    // basic throw: 29 held cycles -> 7 roll steps, then 3 slow steps
    add(0, 1, 4, 1, 1, 0, 0);
    add(0, 1, 4, 2, 1, 0, 0);
    add(0, 1, 4, 3, 1, 0, 0);
    add(0, 1, 4, 4, 1, 0, 0);
    add(0, 1, 4, 5, 1, 0, 0);
    add(0, 1, 4, 6, 1, 0, 0);
    add(0, 1, 4, 1, 1, 0, 0);
    add(0, 1, 1, 2, 1, 0, 0);
    add(0, 0, 4, 2, 1, 0, 0);
    add(0, 0, 8, 3, 1, 0, 0);
    add(0, 0, 12, 4, 1, 0, 0);
    add(0, 0, 1, 5, 0, 1, 1);
    add(0, 0, 3, 5, 0, 0, 1);
    // short press: two held cycles, done 24 cycles after the fall
    add(0, 1, 2, 5, 1, 0, 1);
    add(0, 0, 4, 5, 1, 0, 1);
    add(0, 0, 8, 6, 1, 0, 1);
    add(0, 0, 12, 1, 1, 0, 1);
    add(0, 0, 1, 2, 0, 1, 2);
    add(0, 0, 3, 2, 0, 0, 2);
    // stop mid-roll at face 4 with the button held
    add(0, 1, 4, 2, 1, 0, 2);
    add(0, 1, 4, 3, 1, 0, 2);
    add(0, 1, 1, 4, 1, 0, 2);
    add(1, 1, 1, 4, 0, 0, 2);
    add(0, 1, 3, 4, 0, 0, 2);
    add(0, 0, 1, 4, 0, 0, 2);
    add(0, 1, 1, 4, 1, 0, 2);
    add(0, 1, 3, 4, 1, 0, 2);
    add(0, 1, 4, 5, 1, 0, 2);
    add(0, 0, 1, 5, 1, 0, 2);
    add(0, 0, 3, 5, 1, 0, 2);
    add(0, 0, 8, 6, 1, 0, 2);
    add(0, 0, 12, 1, 1, 0, 2);
    add(0, 0, 1, 2, 0, 1, 3);
    add(0, 0, 2, 2, 0, 0, 3);
    // re-press during SLOW, held through DONE
    add(0, 1, 1, 2, 1, 0, 3);
    add(0, 0, 1, 2, 1, 0, 3);
    add(0, 0, 3, 2, 1, 0, 3);
    add(0, 1, 8, 3, 1, 0, 3);
    add(0, 1, 12, 4, 1, 0, 3);
    add(0, 1, 1, 5, 0, 1, 4);
    add(0, 1, 3, 5, 0, 0, 4);
    add(0, 0, 1, 5, 0, 0, 4);
    add(0, 1, 1, 5, 1, 0, 4);
    add(0, 0, 1, 5, 1, 0, 4);
    add(0, 0, 3, 5, 1, 0, 4);
    add(0, 0, 8, 6, 1, 0, 4);
    add(0, 0, 12, 1, 1, 0, 4);
    add(0, 0, 1, 2, 0, 1, 5);
    add(0, 0, 2, 2, 0, 0, 5);

    rst_n  = 1'b0;
    stop   = 1'b0;
    btn_in = 1'b0;
    m_reset();

    for (int i = 0; i < 3; i++) begin
      btn_in = ~btn_in;
      @(posedge clk);
      #1;
      chk_rst("reset_hold");
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      stop   = tbl[i].stp;
      btn_in = tbl[i].btn;
      for (int r = 0; r < tbl[i].n; r++) begin
        cyc();
        chk($sformatf("tbl%0d", i), pk_a(),
            pk(tbl[i].face, tbl[i].roll, tbl[i].dn, tbl[i].thr));
      end
    end
    stop   = 1'b0;
    btn_in = 1'b0;

    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        btn_in = ~btn_in;
        hold   = $urandom_range(1, 40);
      end
      hold--;
      stop = ($urandom_range(0, 24) == 0);
      cyc();
    end
    stop   = 1'b0;
    btn_in = 1'b1;
    repeat (6) cyc();

    #2;
    rst_n = 1'b0;
    #1;
    chk_rst("reset_async");
    m_reset();
    for (int i = 0; i < 3; i++) begin
      btn_in = ~btn_in;
      @(posedge clk);
      #1;
      chk_rst("reset_mid");
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;

    ndone = 0;
    for (int t = 0; t < 256; t++) begin
      for (int p = 0; p < 4; p++) begin
        btn_in = (p == 0);
        cyc();
        if (done_b) begin
          ndone++;
          chk("wrap_thr", int'(throws_b), ndone % 256);
        end
      end
    end
    btn_in = 1'b0;
    repeat (3) cyc();
    chk("wrap_count", ndone, 256);
    chk("wrap_final", int'(throws_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
